// File: rtl/scope_pkg.sv
// Shared state encoding, width defaults and pointer arithmetic for the capture controller.
package scope_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 9;

    typedef enum logic [2:0] {
        StIdle,
        StPretrig,
        StWaitTrig,
        StPosttrig,
        StDone
    } state_e;

    // (a - b) mod len for a < len and b <= len, without a divider.
    function automatic int unsigned wrap_sub(input int unsigned a, input int unsigned b,
                                             input int unsigned len);
        return (a >= b) ? (a - b) : (a + len - b);
    endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Sample input, trigger setup, frame RAM write port and readout handshake of capture_ctrl.
interface capture_ctrl_if
    import scope_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic              sample_en;
    logic [DATA_W-1:0] adc_db;
    logic [DATA_W-1:0] trig_level;
    logic              trig_slope;
    logic              trig_auto;
    logic              continuous;
    logic              arm;
    logic              frame_ack;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_ready;
    logic [ADDR_W-1:0] frame_base;
    logic              forced;
    logic              busy;

    modport master (
        output sample_en, adc_db, trig_level, trig_slope, trig_auto, continuous, arm, frame_ack,
        input  wr_en, wr_addr, wr_data, frame_ready, frame_base, forced, busy
    );

    modport slave (
        input  sample_en, adc_db, trig_level, trig_slope, trig_auto, continuous, arm, frame_ack,
        output wr_en, wr_addr, wr_data, frame_ready, frame_base, forced, busy
    );

endinterface

// File: rtl/trig_detect.sv
// Level/slope trigger comparator; remembers the previous sample on every strobe.
module trig_detect #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              i_sample_en,
    input  logic [DATA_W-1:0] i_adc_db,
    input  logic [DATA_W-1:0] i_level,
    input  logic              i_slope,
    output logic              o_hit
);

    logic [DATA_W-1:0] r_prev;
    logic              w_rise;
    logic              w_fall;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else if (i_sample_en) begin
            r_prev <= i_adc_db;
        end
    end

    assign w_rise = (r_prev < i_level) && (i_adc_db >= i_level);
    assign w_fall = (r_prev > i_level) && (i_adc_db <= i_level);
    assign o_hit  = i_sample_en && (i_slope ? w_rise : w_fall);

endmodule

// File: rtl/capture_ctrl.sv
// Triggered acquisition writer: circular pre-trigger history, one frame per trigger,
// frame handed to the readout through frame_ready/frame_ack.
module capture_ctrl
    import scope_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned FRAME_LEN    = 200,
    parameter int unsigned PRE_TRIG     = 50,
    parameter int unsigned AUTO_TIMEOUT = 4095
) (
    input logic           sys_clk,
    input logic           rst_n,
    capture_ctrl_if.slave bus
);

    localparam int unsigned POST_LEN = FRAME_LEN - PRE_TRIG;
    localparam int unsigned CNT_W    = $clog2(FRAME_LEN + 1);
    localparam int unsigned TO_W     = $clog2(AUTO_TIMEOUT + 2);

    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'((PRE_TRIG == 0) ? 0 : PRE_TRIG - 1);
    localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT);

    state_e              r_state, w_state;
    logic [ADDR_W-1:0]   r_ptr, w_ptr;
    logic [ADDR_W-1:0]   r_trig_ptr, w_trig_ptr;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [TO_W-1:0]     r_to_cnt, w_to_cnt;
    logic                r_wr_en, w_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr;
    logic [DATA_W-1:0]   r_wr_data, w_wr_data;
    logic                r_finish, w_finish;
    logic                r_frame_ready, w_frame_ready;
    logic [ADDR_W-1:0]   r_frame_base, w_frame_base;
    logic                r_forced, w_forced;
    logic                r_acked, w_acked;
    logic                w_hit;
    logic                w_write;

    trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig_detect (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .i_sample_en (bus.sample_en),
        .i_adc_db    (bus.adc_db),
        .i_level     (bus.trig_level),
        .i_slope     (bus.trig_slope),
        .o_hit       (w_hit)
    );

    assign w_write = bus.sample_en &&
                     (r_state inside {StPretrig, StWaitTrig, StPosttrig});

    always_comb begin
        w_state       = r_state;
        w_ptr         = r_ptr;
        w_trig_ptr    = r_trig_ptr;
        w_cnt         = r_cnt;
        w_to_cnt      = r_to_cnt;
        w_wr_en       = 1'b0;
        w_wr_addr     = r_wr_addr;
        w_wr_data     = r_wr_data;
        w_finish      = 1'b0;
        w_frame_ready = r_frame_ready | r_finish;
        w_frame_base  = r_frame_base;
        w_forced      = r_forced;
        w_acked       = 1'b0;

        if (w_write) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_ptr;
            w_wr_data = bus.adc_db;
            w_ptr     = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                if (bus.arm || (bus.continuous && r_acked)) begin
                    w_state  = (PRE_TRIG == 0) ? StWaitTrig : StPretrig;
                    w_cnt    = '0;
                    w_to_cnt = '0;
                    w_forced = 1'b0;
                end
            end
            StPretrig: begin
                // Triggers are ignored here, including on the sample that completes the history.
                if (bus.sample_en) begin
                    if (r_cnt == PRE_LAST) begin
                        w_state = StWaitTrig;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            StWaitTrig: begin
                if (bus.sample_en) begin
                    if (w_hit || (bus.trig_auto && (r_to_cnt == TO_LAST))) begin
                        w_forced   = !w_hit;
                        w_trig_ptr = r_ptr;
                        w_cnt      = CNT_W'(1);
                        if (POST_LEN == 1) begin
                            w_finish = 1'b1;
                            w_state  = StDone;
                        end else begin
                            w_state = StPosttrig;
                        end
                    end else if (r_to_cnt != TO_LAST) begin
                        w_to_cnt = r_to_cnt + 1'b1;
                    end
                end
            end
            StPosttrig: begin
                if (bus.sample_en) begin
                    if (r_cnt == POST_LAST) begin
                        w_finish = 1'b1;
                        w_state  = StDone;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            StDone: begin
                if (bus.frame_ack && r_frame_ready) begin
                    w_frame_ready = 1'b0;
                    w_acked       = 1'b1;
                    w_state       = StIdle;
                end
            end
            default: w_state = StIdle;
        endcase

        if (w_finish) begin
            w_frame_base = ADDR_W'(wrap_sub(32'(w_trig_ptr), PRE_TRIG, FRAME_LEN));
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_ptr         <= '0;
            r_trig_ptr    <= '0;
            r_cnt         <= '0;
            r_to_cnt      <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_finish      <= 1'b0;
            r_frame_ready <= 1'b0;
            r_frame_base  <= '0;
            r_forced      <= 1'b0;
            r_acked       <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_ptr         <= w_ptr;
            r_trig_ptr    <= w_trig_ptr;
            r_cnt         <= w_cnt;
            r_to_cnt      <= w_to_cnt;
            r_wr_en       <= w_wr_en;
            r_wr_addr     <= w_wr_addr;
            r_wr_data     <= w_wr_data;
            r_finish      <= w_finish;
            r_frame_ready <= w_frame_ready;
            r_frame_base  <= w_frame_base;
            r_forced      <= w_forced;
            r_acked       <= w_acked;
        end
    end

    assign bus.wr_en       = r_wr_en;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;
    assign bus.frame_ready = r_frame_ready;
    assign bus.frame_base  = r_frame_base;
    assign bus.forced      = r_forced;
    assign bus.busy        = r_state inside {StPretrig, StWaitTrig, StPosttrig};

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: stimulus queues expected writes/frames, a monitor checks them.
module tb_capture_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 9;
    localparam int unsigned FL = 200;
    localparam int unsigned PT = 50;
    localparam int unsigned AT = 15;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [AW-1:0] base;
        logic          forced;
    } frm_t;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    capture_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    capture_ctrl #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .FRAME_LEN    (FL),
        .PRE_TRIG     (PT),
        .AUTO_TIMEOUT (AT)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #20 sys_clk = ~sys_clk;

    wr_t         exp_wr[$];
    frm_t        exp_frm[$];
    int unsigned exp_ptr  = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic        prev_wr_en = 1'b0;
    logic        prev_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write and every frame_ready rise must match the head of its queue.
    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected wr_en", 32'(bus.wr_en), 32'd0);
                end else begin
                    check("wr_addr", 32'(bus.wr_addr), 32'(exp_wr[0].addr));
                    check("wr_data", 32'(bus.wr_data), 32'(exp_wr[0].data));
                    exp_wr.delete(0);
                end
                check("wr_addr in range", 32'(bus.wr_addr < AW'(FL)), 32'd1);
            end
            if (bus.frame_ready && !prev_ready) begin
                if (exp_frm.size() == 0) begin
                    check("unexpected frame_ready", 32'(bus.frame_ready), 32'd0);
                end else begin
                    check("frame_base", 32'(bus.frame_base), 32'(exp_frm[0].base));
                    check("forced", 32'(bus.forced), 32'(exp_frm[0].forced));
                    check("ready one cycle after last wr_en", 32'(prev_wr_en), 32'd1);
                    exp_frm.delete(0);
                end
            end
        end
        prev_wr_en <= bus.wr_en;
        prev_ready <= bus.frame_ready;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit wr);
        bus.sample_en = 1'b1;
        bus.adc_db    = d;
        if (wr) begin
            exp_wr.push_back({AW'(exp_ptr), d});
            exp_ptr = (exp_ptr == FL - 1) ? 0 : exp_ptr + 1;
        end
        tick();
        bus.sample_en = 1'b0;
        tick();
    endtask

    task automatic arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        check("busy after arm", 32'(bus.busy), 32'd1);
    endtask

    task automatic pre(input int unsigned start, input int unsigned step);
        for (int i = 0; i < int'(PT); i++) send(DW'(start + i * step), 1'b1);
    endtask

    task automatic trig_and_post(input int unsigned tv, input int unsigned step, input bit frc);
        exp_frm.push_back({AW'((exp_ptr + FL - PT) % FL), frc});
        for (int i = 0; i < int'(FL - PT); i++) send(DW'(tv + i * step), 1'b1);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.frame_ready && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(bus.frame_ready), 32'd1);
        check("busy low in DONE", 32'(bus.busy), 32'd0);
    endtask

    // A discarded sample in DONE, then ack together with another sample, 3 cycles on.
    task automatic ack();
        tick();
        send(DW'(55), 1'b0);
        bus.frame_ack = 1'b1;
        bus.sample_en = 1'b1;
        bus.adc_db    = DW'(66);
        tick();
        bus.frame_ack = 1'b0;
        bus.sample_en = 1'b0;
        check("frame_ready cleared by ack", 32'(bus.frame_ready), 32'd0);
        check("busy low after ack", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_en  = 1'b0;
        bus.adc_db     = '0;
        bus.trig_level = '0;
        bus.trig_slope = 1'b1;
        bus.trig_auto  = 1'b0;
        bus.continuous = 1'b0;
        bus.arm        = 1'b0;
        bus.frame_ack  = 1'b0;
        repeat (3) tick();
        check("reset wr_en", 32'(bus.wr_en), 32'd0);
        check("reset wr_addr", 32'(bus.wr_addr), 32'd0);
        check("reset frame_ready", 32'(bus.frame_ready), 32'd0);
        check("reset frame_base", 32'(bus.frame_base), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Rising ramp: history 78..127, trigger at 128, trig_ptr 50, base 0.
        bus.trig_level = DW'(128);
        bus.trig_slope = 1'b1;
        arm();
        pre(78, 1);
        trig_and_post(128, 1, 1'b0);
        wait_ready("ready ramp rising");
        ack();

        // Falling: 200 steps down to 100 crossing 150.
        bus.trig_level = DW'(150);
        bus.trig_slope = 1'b0;
        arm();
        pre(200, 0);
        for (int i = 0; i < 10; i++) send(DW'(200), 1'b1);
        trig_and_post(100, 0, 1'b0);
        wait_ready("ready falling");
        ack();

        // Same step with rising slope: no trigger in normal mode.
        bus.trig_slope = 1'b1;
        arm();
        pre(200, 0);
        for (int i = 0; i < 10; i++) send(DW'(200), 1'b1);
        for (int i = 0; i < 30; i++) send(DW'(100), 1'b1);
        check("no frame on wrong slope", 32'(bus.frame_ready), 32'd0);
        check("still waiting", 32'(bus.busy), 32'd1);
        trig_and_post(200, 0, 1'b0);
        wait_ready("ready after step up");
        ack();

        // Auto mode: constant input, timeout forces the 16th wait sample.
        bus.trig_level = DW'(128);
        bus.trig_auto  = 1'b1;
        arm();
        pre(10, 0);
        for (int i = 0; i < int'(AT); i++) send(DW'(10), 1'b1);
        trig_and_post(10, 0, 1'b1);
        wait_ready("ready forced");
        check("forced held in DONE", 32'(bus.forced), 32'd1);
        ack();
        bus.trig_auto = 1'b0;

        // Long wait: 230 wait writes, pointer wraps more than once.
        arm();
        pre(0, 1);
        for (int i = 0; i < 230; i++) send(DW'((50 + i) % 100), 1'b1);
        trig_and_post(200, 0, 1'b0);
        wait_ready("ready after wrap");
        ack();

        // Continuous: re-arms by itself after the ack.
        bus.continuous = 1'b1;
        arm();
        pre(0, 0);
        trig_and_post(200, 0, 1'b0);
        wait_ready("ready continuous 1");
        ack();
        tick();
        check("re-armed without arm", 32'(bus.busy), 32'd1);
        bus.continuous = 1'b0;
        pre(0, 0);
        trig_and_post(200, 0, 1'b0);
        wait_ready("ready continuous 2");
        ack();
        tick();
        check("stays idle without continuous", 32'(bus.busy), 32'd0);

        // Reset in the middle of the post-trigger phase.
        arm();
        pre(0, 0);
        send(DW'(200), 1'b1);
        for (int i = 0; i < 98; i++) send(DW'(200), 1'b1);
        bus.sample_en = 1'b1;
        bus.adc_db    = DW'(77);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset wr_en", 32'(bus.wr_en), 32'd0);
        check("mid reset wr_addr", 32'(bus.wr_addr), 32'd0);
        check("mid reset wr_data", 32'(bus.wr_data), 32'd0);
        check("mid reset frame_ready", 32'(bus.frame_ready), 32'd0);
        check("mid reset frame_base", 32'(bus.frame_base), 32'd0);
        check("mid reset forced", 32'(bus.forced), 32'd0);
        check("mid reset busy", 32'(bus.busy), 32'd0);
        bus.sample_en = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        exp_ptr = 0;
        repeat (5) tick();
        check("no ready after reset", 32'(bus.frame_ready), 32'd0);
        arm();
        pre(0, 0);
        trig_and_post(200, 0, 1'b0);
        wait_ready("ready after reset");
        ack();
        repeat (4) tick();

        check("all writes seen", 32'(exp_wr.size()), 32'd0);
        check("all frames seen", 32'(exp_frm.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
